degamma_lut_ctrl: RTL

Double-buffered degamma LUT controller between the host configuration path and the degamma pixel datapath. It owns the write port of a two-bank LUT RAM, fills both banks with an identity ramp after reset, and routes host writes to the shadow bank. Host commits are deferred to the timing generator's `frame_end`, so every frame uses one coherent table. The datapath reads the bank selected by `act_bank`.

---
 rtl/degamma_pkg.sv | 23 ++
 rtl/degamma_lut_addr_gen.sv | 36 +++
 rtl/degamma_lut_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/degamma_pkg.sv
// Shared types, default sizes and the identity-ramp helper for the degamma LUT controller.
package degamma_pkg;

    localparam int AW_DEF = 10;
    localparam int DW_DEF = 12;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_PEND = 2'd2,
        ST_COPY = 2'd3
    } state_t;

    // Entry value of the identity ramp: bank index is dropped, index is scaled to full DW range.
    function automatic logic [31:0] identity_entry(input logic [31:0] addr,
                                                   input int aw,
                                                   input int dw);
        logic [31:0] mask;
        mask = (32'd1 << aw) - 32'd1;
        return (addr & mask) << (dw - aw);
    endfunction

endpackage

// File: rtl/degamma_lut_addr_gen.sv
// Loadable up-counter that walks LUT indices for the identity fill and the bank copy.
module degamma_lut_addr_gen
    import degamma_pkg::*;
#(
    parameter int W = AW_DEF + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         adv,
    input  logic [W-1:0] count_max,
    output logic [W-1:0] addr,
    output logic         last
);

    logic [W-1:0] cnt_q, cnt_d;

    // start restarts the walk at 0 in the same cycle it is asserted
    always_comb begin
        addr  = start ? '0 : cnt_q;
        last  = (addr == count_max);
        cnt_d = cnt_q;
        if (start || adv) begin
            cnt_d = last ? '0 : addr + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/degamma_lut_ctrl.sv
// Double-buffered degamma LUT controller: identity fill, shadow-bank host writes, frame-aligned swap.
// Optional post-swap shadow refresh is built when DEGAMMA_LUT_COPY_EN is defined.
//
// state   | meaning
// INIT    | identity ramp written into both banks
// IDLE    | host writes accepted into the shadow bank
// PEND    | commit armed, waiting for frame_end to swap
// COPY    | new active bank mirrored into the new shadow bank
module degamma_lut_ctrl
    import degamma_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_end,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_data,
    input  logic          commit_req,
    output logic          commit_pending,
    output logic          commit_done,
    output logic          init_done,
    output logic          act_bank,
    output logic          lut_we,
    output logic [AW:0]   lut_waddr,
    output logic [DW-1:0] lut_wdata,
    output logic          lut_re,
    output logic [AW:0]   lut_raddr,
    input  logic [DW-1:0] lut_rdata
);

    localparam logic [AW:0] INIT_MAX = '1;
    localparam logic [AW:0] COPY_MAX = {1'b0, {AW{1'b1}}};

    state_t        state_q, state_d;
    logic          act_bank_q, act_bank_d;
    logic          cfg_ready_q, cfg_ready_d;
    logic          commit_pending_q, commit_pending_d;
    logic          commit_done_q, commit_done_d;
    logic          init_done_q, init_done_d;
    logic          lut_we_q, lut_we_d;
    logic [AW:0]   lut_waddr_q, lut_waddr_d;
    logic [DW-1:0] lut_wdata_q, lut_wdata_d;

    logic          gen_start, gen_adv, gen_last;
    logic [AW:0]   gen_max, gen_addr;

`ifdef DEGAMMA_LUT_COPY_EN
    logic          lut_re_q, lut_re_d;
    logic [AW:0]   lut_raddr_q, lut_raddr_d;
    logic          rd_busy_q, rd_busy_d;
    logic          rd_vld_q, rd_vld_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic          sticky_q, sticky_d;
`else
    logic          rdata_unused;
    assign rdata_unused = ^lut_rdata;
`endif

    degamma_lut_addr_gen #(.W(AW + 1)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .start     (gen_start),
        .adv       (gen_adv),
        .count_max (gen_max),
        .addr      (gen_addr),
        .last      (gen_last)
    );

    always_comb begin
        state_d       = state_q;
        act_bank_d    = act_bank_q;
        commit_done_d = 1'b0;
        init_done_d   = init_done_q;
        lut_we_d      = 1'b0;
        lut_waddr_d   = lut_waddr_q;
        lut_wdata_d   = lut_wdata_q;
        gen_start     = 1'b0;
        gen_adv       = 1'b0;
        gen_max       = (state_q == ST_INIT) ? INIT_MAX : COPY_MAX;
`ifdef DEGAMMA_LUT_COPY_EN
        lut_re_d      = 1'b0;
        lut_raddr_d   = lut_raddr_q;
        rd_busy_d     = rd_busy_q;
        rd_vld_d      = lut_re_q;
        rd_idx_d      = lut_raddr_q[AW-1:0];
        sticky_d      = sticky_q;
`endif
        case (state_q)
            ST_INIT: begin
                gen_adv     = 1'b1;
                lut_we_d    = 1'b1;
                lut_waddr_d = gen_addr;
                lut_wdata_d = DW'(identity_entry(32'(gen_addr), AW, DW));
                if (gen_last) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                init_done_d = 1'b1;
                if (cfg_valid && cfg_ready_q) begin
                    lut_we_d    = 1'b1;
                    lut_waddr_d = {~act_bank_q, cfg_addr};
                    lut_wdata_d = cfg_data;
                end
                if (commit_req) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (frame_end) begin
                    act_bank_d    = ~act_bank_q;
                    commit_done_d = 1'b1;
`ifdef DEGAMMA_LUT_COPY_EN
                    // first read is issued on the swap edge so COPY spans exactly 2^AW+2 cycles
                    state_d     = ST_COPY;
                    gen_start   = 1'b1;
                    lut_re_d    = 1'b1;
                    lut_raddr_d = {act_bank_d, gen_addr[AW-1:0]};
                    rd_busy_d   = ~gen_last;
`else
                    state_d     = ST_IDLE;
`endif
                end
            end
            ST_COPY: begin
`ifdef DEGAMMA_LUT_COPY_EN
                if (rd_busy_q) begin
                    gen_adv     = 1'b1;
                    lut_re_d    = 1'b1;
                    lut_raddr_d = {act_bank_q, gen_addr[AW-1:0]};
                    rd_busy_d   = ~gen_last;
                end
                if (rd_vld_q) begin
                    lut_we_d    = 1'b1;
                    lut_waddr_d = {~act_bank_q, rd_idx_q};
                    lut_wdata_d = lut_rdata;
                end
                if (commit_req) sticky_d = 1'b1;
                if (!rd_busy_q && !lut_re_q && !rd_vld_q) begin
                    state_d  = (sticky_q || commit_req) ? ST_PEND : ST_IDLE;
                    sticky_d = 1'b0;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_INIT;
        endcase
        cfg_ready_d      = (state_d == ST_IDLE) && (state_q != ST_INIT);
        commit_pending_d = (state_d == ST_PEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_INIT;
            act_bank_q       <= 1'b0;
            cfg_ready_q      <= 1'b0;
            commit_pending_q <= 1'b0;
            commit_done_q    <= 1'b0;
            init_done_q      <= 1'b0;
            lut_we_q         <= 1'b0;
            lut_waddr_q      <= '0;
            lut_wdata_q      <= '0;
`ifdef DEGAMMA_LUT_COPY_EN
            lut_re_q         <= 1'b0;
            lut_raddr_q      <= '0;
            rd_busy_q        <= 1'b0;
            rd_vld_q         <= 1'b0;
            rd_idx_q         <= '0;
            sticky_q         <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            act_bank_q       <= act_bank_d;
            cfg_ready_q      <= cfg_ready_d;
            commit_pending_q <= commit_pending_d;
            commit_done_q    <= commit_done_d;
            init_done_q      <= init_done_d;
            lut_we_q         <= lut_we_d;
            lut_waddr_q      <= lut_waddr_d;
            lut_wdata_q      <= lut_wdata_d;
`ifdef DEGAMMA_LUT_COPY_EN
            lut_re_q         <= lut_re_d;
            lut_raddr_q      <= lut_raddr_d;
            rd_busy_q        <= rd_busy_d;
            rd_vld_q         <= rd_vld_d;
            rd_idx_q         <= rd_idx_d;
            sticky_q         <= sticky_d;
`endif
        end
    end

    assign cfg_ready      = cfg_ready_q;
    assign commit_pending = commit_pending_q;
    assign commit_done    = commit_done_q;
    assign init_done      = init_done_q;
    assign act_bank       = act_bank_q;
    assign lut_we         = lut_we_q;
    assign lut_waddr      = lut_waddr_q;
    assign lut_wdata      = lut_wdata_q;
`ifdef DEGAMMA_LUT_COPY_EN
    assign lut_re         = lut_re_q;
    assign lut_raddr      = lut_raddr_q;
`else
    assign lut_re         = 1'b0;
    assign lut_raddr      = '0;
`endif

endmodule
